pwm_width_decoder: RTL and testbench

- Parametrised next-generation PWM symbol decoder for the SDR receive path; sits after the DDC, fed one signed baseband sample per clock.
- Compares samples against a reference level using a hysteresis comparator and measures high-pulse width in samples.
- Quantises the width into a signed symbol with a valid strobe.
- Adds runt rejection, timeout/overflow detection, saturation and a truncated-pulse guard.

---
 rtl/pwm_width_decoder.sv | 231 +++++++++++++++++++++++
 tb/tb_pwm_width_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_width_decoder.sv
// PWM symbol decoder for the SDR receive path.
// The decoder registers each baseband sample and the reference level. A
// hysteresis comparator then turns them into a clean logic level. The FSM
// measures how many samples each high pulse lasts and quantises that width
// into a saturated, non-negative signed symbol. Pulses that are too short
// (runt) or too long (overflow) are reported instead of being decoded. A
// decoder that starts up on a high level does not measure until it has seen
// a decisive low, so a truncated pulse is never decoded.
module pwm_width_decoder #(
    parameter int DATA_W    = 16,
    parameter int CNT_W     = 12,
    parameter int SYM_W     = 8,
    parameter int BIN_SHIFT = 2,
    parameter int HYST      = 8,
    parameter int MIN_WIDTH = 4,
    parameter int MAX_WIDTH = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] ref_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [SYM_W-1:0]  decoded_symbol,
    output logic              symbol_valid,
    output logic [CNT_W-1:0]  pulse_width,
    output logic              runt_err,
    output logic              overflow_err,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_MEASURE = 2'd2
    } state_t;

    // Rounding term that makes the width-to-symbol division round to nearest.
    localparam int ROUND_INT = (BIN_SHIFT > 0) ? (1 << ((BIN_SHIFT > 0) ? (BIN_SHIFT - 1) : 0)) : 0;

    localparam logic signed [DATA_W+1:0] HYST_C    = (DATA_W+2)'(HYST);
    localparam logic [CNT_W-1:0]         MIN_C     = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0]         MAX_C     = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W:0]           ROUND_C   = (CNT_W+1)'(ROUND_INT);
    localparam logic [CNT_W:0]           SYM_MAX_C = (CNT_W+1)'((2 ** (SYM_W - 1)) - 1);

    // Stage 1 registers
    logic signed [DATA_W-1:0] data_q_r;
    logic signed [DATA_W-1:0] ref_q_r;

    // Stage 2 comparator
    logic signed [DATA_W+1:0] data_ext_s;
    logic signed [DATA_W+1:0] ref_ext_s;
    logic signed [DATA_W+1:0] hi_thr_s;
    logic signed [DATA_W+1:0] lo_thr_s;
    logic                     comp_q_r;
    logic                     comp_valid_r;
    logic                     comp_q_next_s;
    logic                     comp_valid_next_s;

    // FSM and measurement
    state_t                   state_r;
    state_t                   state_next_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_next_s;
    logic [CNT_W-1:0]         cnt_inc_s;
    logic [CNT_W:0]           rounded_s;
    logic [SYM_W-1:0]         sym_calc_s;

    // Registered outputs and their next values
    logic [SYM_W-1:0]         decoded_symbol_r;
    logic [CNT_W-1:0]         pulse_width_r;
    logic                     symbol_valid_r;
    logic                     runt_err_r;
    logic                     overflow_err_r;
    logic [SYM_W-1:0]         sym_next_s;
    logic [CNT_W-1:0]         width_next_s;
    logic                     valid_next_s;
    logic                     runt_next_s;
    logic                     ovf_next_s;

    // Stage 1: capture the sample and the reference level on every edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q_r <= {DATA_W{1'b0}};
            ref_q_r  <= {DATA_W{1'b0}};
        end else begin
            data_q_r <= data_in;
            ref_q_r  <= ref_in;
        end
    end

    // Hysteresis decision, evaluated two bits wider so ref +/- HYST cannot wrap.
    always_comb begin
        data_ext_s        = {{2{data_q_r[DATA_W-1]}}, data_q_r};
        ref_ext_s         = {{2{ref_q_r[DATA_W-1]}}, ref_q_r};
        hi_thr_s          = ref_ext_s + HYST_C;
        lo_thr_s          = ref_ext_s - HYST_C;
        comp_q_next_s     = comp_q_r;
        comp_valid_next_s = comp_valid_r;
        if (data_ext_s >= hi_thr_s) begin
            comp_q_next_s     = 1'b1;
            comp_valid_next_s = 1'b1;
        end else if (data_ext_s <= lo_thr_s) begin
            comp_q_next_s     = 1'b0;
            comp_valid_next_s = 1'b1;
        end else begin
            comp_q_next_s     = comp_q_r;
            comp_valid_next_s = comp_valid_r;
        end
        // The level keeps tracking while disabled, but it is not trusted
        // again until a fresh decisive sample arrives.
        if (!enable) begin
            comp_valid_next_s = 1'b0;
        end else begin
            comp_valid_next_s = comp_valid_next_s;
        end
    end

    // Stage 2: register the comparator level and its validity.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            comp_q_r     <= 1'b0;
            comp_valid_r <= 1'b0;
        end else begin
            comp_q_r     <= comp_q_next_s;
            comp_valid_r <= comp_valid_next_s;
        end
    end

    // Width-to-symbol quantisation with round-to-nearest and saturation.
    always_comb begin
        cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        rounded_s = ({1'b0, cnt_r} + ROUND_C) >> BIN_SHIFT;
        if (rounded_s > SYM_MAX_C) begin
            sym_calc_s = SYM_MAX_C[SYM_W-1:0];
        end else begin
            sym_calc_s = rounded_s[SYM_W-1:0];
        end
    end

    // FSM next state, counter and output decisions.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        valid_next_s = 1'b0;
        runt_next_s  = 1'b0;
        ovf_next_s   = 1'b0;
        width_next_s = pulse_width_r;
        sym_next_s   = decoded_symbol_r;
        if (!enable) begin
            state_next_s = ST_IDLE;
            cnt_next_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_next_s = {CNT_W{1'b0}};
                    if (comp_valid_r && !comp_q_r) begin
                        state_next_s = ST_ARMED;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (comp_q_r) begin
                        cnt_next_s   = {{(CNT_W-1){1'b0}}, 1'b1};
                        state_next_s = ST_MEASURE;
                    end else begin
                        cnt_next_s   = {CNT_W{1'b0}};
                        state_next_s = ST_ARMED;
                    end
                end
                ST_MEASURE: begin
                    if (comp_q_r) begin
                        if (cnt_inc_s == MAX_C) begin
                            // Over-long pulse: discard and demand a decisive low.
                            ovf_next_s   = 1'b1;
                            cnt_next_s   = {CNT_W{1'b0}};
                            state_next_s = ST_IDLE;
                        end else begin
                            cnt_next_s   = cnt_inc_s;
                            state_next_s = ST_MEASURE;
                        end
                    end else begin
                        cnt_next_s   = {CNT_W{1'b0}};
                        state_next_s = ST_ARMED;
                        if (cnt_r < MIN_C) begin
                            runt_next_s = 1'b1;
                        end else begin
                            valid_next_s = 1'b1;
                            width_next_s = cnt_r;
                            sym_next_s   = sym_calc_s;
                        end
                    end
                end
                default: begin
                    cnt_next_s   = {CNT_W{1'b0}};
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, width counter and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            cnt_r            <= {CNT_W{1'b0}};
            symbol_valid_r   <= 1'b0;
            runt_err_r       <= 1'b0;
            overflow_err_r   <= 1'b0;
            pulse_width_r    <= {CNT_W{1'b0}};
            decoded_symbol_r <= {SYM_W{1'b0}};
        end else begin
            state_r          <= state_next_s;
            cnt_r            <= cnt_next_s;
            symbol_valid_r   <= valid_next_s;
            runt_err_r       <= runt_next_s;
            overflow_err_r   <= ovf_next_s;
            pulse_width_r    <= width_next_s;
            decoded_symbol_r <= sym_next_s;
        end
    end

    assign decoded_symbol = decoded_symbol_r;
    assign symbol_valid   = symbol_valid_r;
    assign pulse_width    = pulse_width_r;
    assign runt_err       = runt_err_r;
    assign overflow_err   = overflow_err_r;
    assign busy           = (state_r == ST_MEASURE);

endmodule

// File: tb/tb_pwm_width_decoder.sv
// Directed testbench for pwm_width_decoder with hand-computed expectations.
// Strobes and busy cycles are counted on the falling edge; each scenario
// compares the counts accumulated since its start and the held outputs.
module tb_pwm_width_decoder;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [15:0] ref_in;
    logic [15:0] data_in;
    logic [7:0]  decoded_symbol;
    logic        symbol_valid;
    logic [11:0] pulse_width;
    logic        runt_err;
    logic        overflow_err;
    logic        busy;

    int tests_run;
    int tests_failed;

    int n_valid;
    int n_runt;
    int n_ovf;
    int n_busy;
    int n_excl;

    int b_valid;
    int b_runt;
    int b_ovf;
    int b_busy;

    pwm_width_decoder dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .ref_in         (ref_in),
        .data_in        (data_in),
        .decoded_symbol (decoded_symbol),
        .symbol_valid   (symbol_valid),
        .pulse_width    (pulse_width),
        .runt_err       (runt_err),
        .overflow_err   (overflow_err),
        .busy           (busy)
    );

    // 10 ns sample clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Count strobe and busy cycles away from the active edge.
    always @(negedge clock) begin
        if (symbol_valid === 1'b1) n_valid++;
        if (runt_err === 1'b1)     n_runt++;
        if (overflow_err === 1'b1) n_ovf++;
        if (busy === 1'b1)         n_busy++;
        if ((int'(symbol_valid === 1'b1) + int'(runt_err === 1'b1) + int'(overflow_err === 1'b1)) > 1) n_excl++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] v, input int n);
        repeat (n) begin
            @(negedge clock);
            data_in = v;
        end
    endtask

    task automatic snap();
        b_valid = n_valid;
        b_runt  = n_runt;
        b_ovf   = n_ovf;
        b_busy  = n_busy;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        n_valid = 0; n_runt = 0; n_ovf = 0; n_busy = 0; n_excl = 0;
        b_valid = 0; b_runt = 0; b_ovf = 0; b_busy = 0;
        reset   = 1'b1;
        enable  = 1'b1;
        ref_in  = 16'd65;
        data_in = 16'd0;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_sym",   {24'd0, decoded_symbol}, 32'd0);
        check("rst_width", {20'd0, pulse_width},    32'd0);
        check("rst_strb",  {29'd0, symbol_valid, runt_err, overflow_err}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        reset = 1'b0;

        // 1. Clean pulse of 20 samples
        snap();
        drive(16'd0, 4);
        drive(16'd200, 20);
        drive(16'd0, 6);
        check("s1_valid", n_valid - b_valid, 32'd1);
        check("s1_width", {20'd0, pulse_width}, 32'd20);
        check("s1_sym",   {24'd0, decoded_symbol}, 32'd5);
        check("s1_busy",  n_busy - b_busy, 32'd20);

        // 2. In-band samples extend the high level
        snap();
        drive(16'd0, 4);
        drive(16'd200, 10);
        drive(16'd60, 3);
        drive(16'd200, 10);
        drive(16'd0, 6);
        check("s2_valid", n_valid - b_valid, 32'd1);
        check("s2_width", {20'd0, pulse_width}, 32'd23);
        check("s2_sym",   {24'd0, decoded_symbol}, 32'd6);
        check("s2_runt",  n_runt - b_runt, 32'd0);

        // 3. Start guard after reset on a high level, then a runt
        data_in = 16'd200;
        pulse_reset();
        snap();
        drive(16'd200, 8);
        check("s3_guard_valid", n_valid - b_valid, 32'd0);
        check("s3_guard_busy",  n_busy - b_busy, 32'd0);
        drive(16'd0, 2);
        drive(16'd200, 3);
        drive(16'd0, 6);
        check("s3_runt",  n_runt - b_runt, 32'd1);
        check("s3_valid", n_valid - b_valid, 32'd0);

        // 4. Overflow, then recovery
        snap();
        drive(16'd0, 2);
        drive(16'd200, 1100);
        check("s4_ovf",   n_ovf - b_ovf, 32'd1);
        check("s4_valid", n_valid - b_valid, 32'd0);
        check("s4_busy",  n_busy - b_busy, 32'd1022);
        drive(16'd0, 2);
        drive(16'd200, 8);
        drive(16'd0, 6);
        check("s4_rec_valid", n_valid - b_valid, 32'd1);
        check("s4_rec_width", {20'd0, pulse_width}, 32'd8);
        check("s4_rec_sym",   {24'd0, decoded_symbol}, 32'd2);

        // 5. Saturation of the symbol
        snap();
        drive(16'd0, 2);
        drive(16'd200, 600);
        drive(16'd0, 6);
        check("s5_valid", n_valid - b_valid, 32'd1);
        check("s5_width", {20'd0, pulse_width}, 32'd600);
        check("s5_sym",   {24'd0, decoded_symbol}, 32'd127);

        // 6a. Reset during the 10th high sample
        snap();
        drive(16'd0, 2);
        drive(16'd200, 10);
        #2;
        check("s6_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("s6_rst_sym",   {24'd0, decoded_symbol}, 32'd0);
        check("s6_rst_width", {20'd0, pulse_width},    32'd0);
        check("s6_rst_busy",  {31'd0, busy}, 32'd0);
        check("s6_rst_strb",  {29'd0, symbol_valid, runt_err, overflow_err}, 32'd0);
        drive(16'd200, 2);
        reset = 1'b0;
        drive(16'd200, 5);
        drive(16'd0, 6);
        check("s6_rst_nostrb", (n_valid - b_valid) + (n_runt - b_runt) + (n_ovf - b_ovf), 32'd0);

        // 6b. Enable dropped mid-pulse holds the previous symbol
        drive(16'd200, 12);
        drive(16'd0, 6);
        check("s6_pre_sym",   {24'd0, decoded_symbol}, 32'd3);
        check("s6_pre_width", {20'd0, pulse_width}, 32'd12);
        snap();
        drive(16'd200, 5);
        @(negedge clock);
        enable = 1'b0;
        drive(16'd200, 5);
        drive(16'd0, 6);
        enable = 1'b1;
        drive(16'd0, 4);
        check("s6_en_nostrb", (n_valid - b_valid) + (n_runt - b_runt) + (n_ovf - b_ovf), 32'd0);
        check("s6_en_sym",   {24'd0, decoded_symbol}, 32'd3);
        check("s6_en_width", {20'd0, pulse_width}, 32'd12);

        // Recovery after enable returns
        snap();
        drive(16'd200, 8);
        drive(16'd0, 6);
        check("s6_rec_valid", n_valid - b_valid, 32'd1);
        check("s6_rec_sym",   {24'd0, decoded_symbol}, 32'd2);

        check("strobe_excl", n_excl, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
